// File: rtl/x_fifo_reader_pkg.sv
// x_fifo_pkg: shared types for the FIFO read-side adapter.
//   occ_t       - 2-bit buffer occupancy (0..2)
//   buf_state_e - skid buffer state, encoded so the state value equals occupancy
//   rd_lat_ok   - legality check for the FIFO read latency parameter
package x_fifo_pkg;

  localparam int unsigned OCC_W = 2;

  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_TWO   = 2'd2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Only zero- and one-cycle FIFO read latencies are supported.
  function automatic logic rd_lat_ok(input int unsigned lat);
    return (lat <= 32'd1);
  endfunction

endpackage

// File: rtl/x_fifo_reader_if.sv
// x_fifo_reader_if: FIFO read port plus valid/ready output stream.
//   flush        - synchronous discard request
//   fifo_empty_n - FIFO holds at least one word
//   fifo_re      - FIFO pop request
//   fifo_dout    - FIFO read data
//   m_valid/m_ready/m_data - output stream
//   occ          - buffer occupancy (debug)
// master: the adapter; slave: FIFO + consumer side.
interface x_fifo_reader_if
  import x_fifo_pkg::*;
#(
  parameter int unsigned DW = 8
);

  logic          flush;
  logic          fifo_empty_n;
  logic          fifo_re;
  logic [DW-1:0] fifo_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  occ_t          occ;

  modport master (
    input  flush, fifo_empty_n, fifo_dout, m_ready,
    output fifo_re, m_valid, m_data, occ
  );

  modport slave (
    output flush, fifo_empty_n, fifo_dout, m_ready,
    input  fifo_re, m_valid, m_data, occ
  );

endinterface

// File: rtl/x_fifo_reader_skid_buf2.sv
// x_skid_buf2: 2-entry FIFO-ordered register buffer.
//   clk, rst - clock, async active-high reset
//   clr      - synchronous clear (wins over push/pop)
//   push/din - write din at the tail
//   pop      - drop the head entry
//   cnt      - occupancy 0..2
//   head     - head entry (entry 0)
module x_skid_buf2
  import x_fifo_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output occ_t          cnt,
  output logic [DW-1:0] head
);

  buf_state_e    state_q, state_d;
  logic [DW-1:0] e0_q, e0_d;
  logic [DW-1:0] e1_q, e1_d;

  // State and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  // Next state: entry 0 is always the head, entry 1 the second word.
  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (clr) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            e0_d    = din;
          end
        end
        ST_ONE: begin
          case ({push, pop})
            2'b10: begin
              state_d = ST_TWO;
              e1_d    = din;
            end
            2'b01: state_d = ST_EMPTY;
            2'b11: e0_d = din;
            default: ;
          endcase
        end
        ST_TWO: begin
          case ({push, pop})
            2'b01: begin
              state_d = ST_ONE;
              e0_d    = e1_q;
            end
            2'b11: begin
              e0_d = e1_q;
              e1_d = din;
            end
            default: ;
          endcase
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // A push into a full buffer without a pop would lose a word.
  always @(posedge clk) begin
    if (!rst && !clr) begin
      assert (!(state_q == ST_TWO && push && !pop))
        else $error("x_skid_buf2: push into full buffer");
    end
  end

  assign cnt  = occ_t'(state_q);
  assign head = e0_q;

endmodule

// File: rtl/x_fifo_reader.sv
// x_fifo_reader: read-side adapter turning a FIFO read port into a
// valid/ready stream through a 2-entry buffer.
//   clk, rst - clock, async active-high reset
//   bus      - x_fifo_reader_if.master (FIFO read port, output stream, flush, occ)
// Parameters: DW data width, RD_LAT FIFO read latency (0 or 1).
module x_fifo_reader
  import x_fifo_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  x_fifo_reader_if.master bus
);

  occ_t          cnt;
  logic [DW-1:0] head;
  logic          pop;
  logic          arr;
  logic          infl;
  logic          re;
  logic [2:0]    need_c;

  assign pop = (cnt != OCC_EMPTY) && bus.m_ready;

  // Slots committed next cycle: current words minus the one leaving plus the
  // read already in flight. Issue only when a slot remains for the new read.
  assign need_c = 3'(cnt) - 3'(pop) + 3'(infl);
  assign re     = bus.fifo_empty_n && !bus.flush && !rst && (need_c < 3'(OCC_TWO));

  if (RD_LAT == 0) begin : g_lat0
    assign infl = 1'b0;
    assign arr  = re;
  end else begin : g_lat1
    logic infl_q;

    // Read issued this cycle returns data next cycle; flush already blocks re.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        infl_q <= 1'b0;
      end else begin
        infl_q <= re;
      end
    end

    assign infl = infl_q;
    assign arr  = infl_q;
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (rd_lat_ok(RD_LAT))
        else $error("x_fifo_reader: illegal RD_LAT %0d", RD_LAT);
    end
  end

  x_skid_buf2 #(
    .DW (DW)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.flush),
    .push (arr),
    .pop  (pop),
    .din  (bus.fifo_dout),
    .cnt  (cnt),
    .head (head)
  );

  assign bus.fifo_re = re;
  assign bus.m_valid = (cnt != OCC_EMPTY);
  assign bus.m_data  = head;
  assign bus.occ     = cnt;

endmodule

// File: tb/tb_x_fifo_reader.sv
// tb_x_fifo_reader: scoreboard bench for x_fifo_reader, one instance per
// read latency, each fed by a small behavioural FIFO model.
module tb_x_fifo_reader;
  import x_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  x_fifo_reader_if #(.DW(8)) b1 ();
  x_fifo_reader_if #(.DW(8)) b0 ();

  x_fifo_reader #(.DW(8), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.master));
  x_fifo_reader #(.DW(8), .RD_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.master));

  // FIFO models: memory, pointers, one-cycle registered read for latency 1.
  logic [7:0] mem1 [0:63];
  logic [7:0] mem0 [0:63];
  int         wp1 = 0, rp1 = 0, wp0 = 0, rp0 = 0;
  logic       ne_force = 1'b0;
  logic [7:0] dout1;
  logic [7:0] exp1 [$];
  logic [7:0] exp0 [$];
  logic [7:0] e1_v, e0_v;

  assign b1.fifo_empty_n = ne_force || (wp1 != rp1);
  assign b0.fifo_empty_n = ne_force || (wp0 != rp0);
  assign b1.fifo_dout    = dout1;
  assign b0.fifo_dout    = mem0[rp0[5:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rp1   <= wp1;
      dout1 <= 8'h00;
    end else if (b1.fifo_re) begin
      dout1 <= mem1[rp1[5:0]];
      rp1   <= rp1 + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rp0 <= wp0;
    end else if (b0.fifo_re) begin
      rp0 <= rp0 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem1[wp1[5:0]] = first + 8'(i);
      wp1++;
      exp1.push_back(first + 8'(i));
    end
  endtask

  task automatic load0(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem0[wp0[5:0]] = first + 8'(i);
      wp0++;
      exp0.push_back(first + 8'(i));
    end
  endtask

  task automatic drain1();
    int n = 0;
    while ((exp1.size() != 0 || b1.m_valid) && n < 60) begin
      step();
      n++;
    end
    chk("drain1_left", 32'(exp1.size()), 32'd0);
  endtask

  // Monitors: pop the expected word whenever a transfer happens.
  always @(negedge clk) begin
    if (!rst) begin
      chk("occ1_le2", 32'(b1.occ <= OCC_TWO), 32'd1);
      if (b1.m_valid && b1.m_ready) begin
        if (exp1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb1_extra act=0x%0h exp=none t=%0t", b1.m_data, $time);
        end else begin
          e1_v = exp1.pop_front();
          chk("sb1_data", 32'(b1.m_data), 32'(e1_v));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("occ0_le2", 32'(b0.occ <= OCC_TWO), 32'd1);
      if (b0.m_valid && b0.m_ready) begin
        if (exp0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb0_extra act=0x%0h exp=none t=%0t", b0.m_data, $time);
        end else begin
          e0_v = exp0.pop_front();
          chk("sb0_data", 32'(b0.m_data), 32'(e0_v));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.flush   = 1'b0;
    b0.flush   = 1'b0;
    b1.m_ready = 1'b1;
    b0.m_ready = 1'b1;
    ne_force   = 1'b1;
    rst        = 1'b1;

    // Reset held with the FIFO claiming data.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_re1",    32'(b1.fifo_re), 32'd0);
      chk("rst_valid1", 32'(b1.m_valid), 32'd0);
      chk("rst_data1",  32'(b1.m_data),  32'd0);
      chk("rst_occ1",   32'(b1.occ),     32'd0);
      chk("rst_re0",    32'(b0.fifo_re), 32'd0);
    end
    ne_force = 1'b0;
    rst      = 1'b0;
    step();

    // Streaming, latency 1: first word two cycles after the first read.
    load1(8'h11, 8);
    #1;
    chk("stream_re_T", 32'(b1.fifo_re), 32'd1);
    step();
    chk("stream_valid_T1", 32'(b1.m_valid), 32'd0);
    step();
    chk("stream_valid_T2", 32'(b1.m_valid), 32'd1);
    chk("stream_data_T2",  32'(b1.m_data),  32'h11);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("stream_nogap", 32'(b1.m_valid), 32'd1);
    end
    step();
    chk("stream_done_valid", 32'(b1.m_valid), 32'd0);
    chk("stream_done_left",  32'(exp1.size()), 32'd0);

    // Back-pressure: five stall cycles mid-stream.
    load1(8'h21, 10);
    step();
    step();
    step();
    b1.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_re_low", 32'(b1.fifo_re), 32'd0);
      if (i >= 1) chk("stall_occ2", 32'(b1.occ), 32'd2);
      step();
    end
    b1.m_ready = 1'b1;
    #1;
    chk("release_valid", 32'(b1.m_valid), 32'd1);
    chk("release_re",    32'(b1.fifo_re), 32'd1);
    drain1();

    // Flush with one buffered word and one read in flight.
    load1(8'h31, 6);
    step();
    step();
    step();
    b1.m_ready = 1'b0;
    b1.flush   = 1'b1;
    #1;
    chk("flush_re_low", 32'(b1.fifo_re), 32'd0);
    chk("flush_occ_in", 32'(b1.occ),     32'd1);
    chk("flush_head",   32'(b1.m_data),  32'h32);
    void'(exp1.pop_front());
    void'(exp1.pop_front());
    step();
    b1.flush   = 1'b0;
    b1.m_ready = 1'b1;
    #1;
    chk("flush_occ0",   32'(b1.occ),     32'd0);
    chk("flush_valid0", 32'(b1.m_valid), 32'd0);
    chk("flush_re_next", 32'(b1.fifo_re), 32'd1);
    step();
    step();
    chk("flush_next_word", 32'(b1.m_data), 32'h34);
    drain1();

    // Reset pulsed while the buffer is full.
    load1(8'h41, 8);
    step();
    step();
    step();
    b1.m_ready = 1'b0;
    step();
    step();
    chk("pre_rst_occ2", 32'(b1.occ), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(b1.m_valid), 32'd0);
    chk("async_occ",   32'(b1.occ),     32'd0);
    chk("async_data",  32'(b1.m_data),  32'd0);
    chk("async_re",    32'(b1.fifo_re), 32'd0);
    exp1.delete();
    step();
    step();
    rst = 1'b0;
    b1.m_ready = 1'b1;
    step();
    load1(8'h51, 4);
    step();
    step();
    chk("post_rst_first", 32'(b1.m_data), 32'h51);
    drain1();

    // Zero latency with alternating ready.
    load0(8'hA0, 6);
    #1;
    chk("lat0_re_T", 32'(b0.fifo_re), 32'd1);
    step();
    chk("lat0_valid_T1", 32'(b0.m_valid), 32'd1);
    chk("lat0_data_T1",  32'(b0.m_data),  32'hA0);
    for (int i = 0; i < 40 && exp0.size() != 0; i++) begin
      b0.m_ready = i[0];
      step();
    end
    chk("lat0_left", 32'(exp0.size()), 32'd0);
    b0.m_ready = 1'b1;
    step();
    chk("lat0_idle_valid", 32'(b0.m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
